// File: rtl/rt_pixel_scheduler_if.sv
// rtl/rt_pixel_scheduler_if.sv - frame control, core and framebuffer signals of the pixel scheduler
interface rt_pixel_scheduler_if #(
    parameter int PIX_W = 4,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int AW    = 19
);
    logic             start;
    logic             continuous;
    logic             abort;
    logic             busy;
    logic             frame_done;
    logic [15:0]      frame_count;
    logic             core_enable;
    logic [XW-1:0]    core_x;
    logic [YW-1:0]    core_y;
    logic             core_ready;
    logic [PIX_W-1:0] core_pixel;
    logic             fb_we;
    logic [AW-1:0]    fb_addr;
    logic [PIX_W-1:0] fb_data;
    logic             fb_ready;

    modport master (
        input  start, continuous, abort, core_ready, core_pixel, fb_ready,
        output busy, frame_done, frame_count, core_enable, core_x, core_y,
               fb_we, fb_addr, fb_data
    );

    modport slave (
        output start, continuous, abort, core_ready, core_pixel, fb_ready,
        input  busy, frame_done, frame_count, core_enable, core_x, core_y,
               fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/rt_pixel_scheduler.sv
// rtl/rt_pixel_scheduler.sv - raster-order pixel sequencer between frame control, ray core and framebuffer
module rt_pixel_scheduler #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int PIX_W = 4,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int AW    = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    rt_pixel_scheduler_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE} state_t;

    state_t           state, state_n;
    logic [XW-1:0]    x_q, x_n;
    logic [YW-1:0]    y_q, y_n;
    logic [AW-1:0]    addr_q, addr_n;
    logic [PIX_W-1:0] data_q, data_n;
    logic [15:0]      count_q, count_n;
    logic             done_n;
    logic             core_enable_q, fb_we_q, busy_q, frame_done_q;
    logic             last_x, last_y, transfer;

    assign last_x   = (x_q == XW'(H_RES - 1));
    assign last_y   = (y_q == YW'(V_RES - 1));
    assign transfer = (state == S_WRITE) && bus.fb_ready;

    assign bus.core_enable = core_enable_q;
    assign bus.core_x      = x_q;
    assign bus.core_y      = y_q;
    assign bus.fb_we       = fb_we_q;
    assign bus.fb_addr     = addr_q;
    assign bus.fb_data     = data_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = count_q;

    // Strobes are derived from the next state so every output stays a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            count_q       <= '0;
            core_enable_q <= 1'b0;
            fb_we_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state         <= state_n;
            x_q           <= x_n;
            y_q           <= y_n;
            addr_q        <= addr_n;
            data_q        <= data_n;
            count_q       <= count_n;
            core_enable_q <= (state_n == S_ISSUE);
            fb_we_q       <= (state_n == S_WRITE);
            busy_q        <= (state_n != S_IDLE);
            frame_done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        if (bus.abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state_n = S_ISSUE;
                S_ISSUE: state_n = S_WAIT;
                S_WAIT:  if (bus.core_ready) state_n = S_WRITE;
                S_WRITE: if (transfer) begin
                    state_n = (last_x && last_y && !bus.continuous) ? S_IDLE : S_ISSUE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Address advances alongside X/Y so no Y*H_RES product is ever formed.
    always_comb begin
        x_n     = x_q;
        y_n     = y_q;
        addr_n  = addr_q;
        data_n  = data_q;
        count_n = count_q;
        done_n  = 1'b0;
        if (!bus.abort) begin
            case (state)
                S_IDLE: if (bus.start) begin
                    x_n    = '0;
                    y_n    = '0;
                    addr_n = '0;
                end
                S_WAIT: if (bus.core_ready) data_n = bus.core_pixel;
                S_WRITE: if (transfer) begin
                    if (!last_x) begin
                        x_n    = x_q + 1'b1;
                        addr_n = addr_q + 1'b1;
                    end else if (!last_y) begin
                        x_n    = '0;
                        y_n    = y_q + 1'b1;
                        addr_n = addr_q + 1'b1;
                    end else begin
                        x_n     = '0;
                        y_n     = '0;
                        addr_n  = '0;
                        done_n  = 1'b1;
                        count_n = count_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rt_pixel_scheduler.sv
// tb/tb_rt_pixel_scheduler.sv - randomized self-checking bench for rt_pixel_scheduler
module tb_rt_pixel_scheduler;
    localparam int H = 4;
    localparam int V = 3;
    localparam int NPIX = H * V;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rt_pixel_scheduler_if a ();
    rt_pixel_scheduler_if b ();

    rt_pixel_scheduler #(.H_RES(H), .V_RES(V)) dut   (.clk(clk), .rst(rst), .bus(a));
    rt_pixel_scheduler #(.H_RES(1), .V_RES(1)) b_dut (.clk(clk), .rst(rst), .bus(b));

    int total = 0;
    int bad = 0;
    int core_lat = 2;
    bit core_on = 1'b1;
    int lat_cnt = 0;
    int b_lat_cnt = 0;
    logic [3:0] pix_q[$];
    logic [3:0] b_pix_q[$];
    bit xfer, b_xfer, saw_en, saw_done, b_en, b_done;
    logic [18:0] xa, b_xa;
    logic [9:0]  xx;
    logic [8:0]  xy;
    logic [3:0]  xd, b_xd;
    logic [15:0] exp_count = 16'd0;
    logic [15:0] b_exp_count = 16'd0;

    // Advance one clock; behave as the ray core and note what crossed the edge.
    task automatic cyc();
        logic [3:0] p;
        xfer   = a.fb_we && a.fb_ready;
        xa     = a.fb_addr;
        xx     = a.core_x;
        xy     = a.core_y;
        xd     = a.fb_data;
        b_xfer = b.fb_we && b.fb_ready;
        b_xa   = b.fb_addr;
        b_xd   = b.fb_data;
        @(posedge clk);
        #1;
        saw_en   = a.core_enable;
        saw_done = a.frame_done;
        b_en     = b.core_enable;
        b_done   = b.frame_done;
        a.core_ready = 1'b0;
        a.core_pixel = 4'($urandom);
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0 && core_on) begin
                p = 4'($urandom);
                a.core_ready = 1'b1;
                a.core_pixel = p;
                pix_q.push_back(p);
            end
        end
        if (saw_en) lat_cnt = (core_lat == 0) ? int'($urandom_range(4, 1)) : core_lat;
        b.core_ready = 1'b0;
        if (b_lat_cnt > 0) begin
            b_lat_cnt--;
            if (b_lat_cnt == 0) begin
                p = 4'($urandom);
                b.core_ready = 1'b1;
                b.core_pixel = p;
                b_pix_q.push_back(p);
            end
        end
        if (b_en) b_lat_cnt = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a.start = 1'b0; a.continuous = 1'b0; a.abort = 1'b0;
        a.core_ready = 1'b0; a.core_pixel = '0; a.fb_ready = 1'b1;
        b.start = 1'b0; b.continuous = 1'b0; b.abort = 1'b0;
        b.core_ready = 1'b0; b.core_pixel = '0; b.fb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({a.core_enable, a.fb_we, a.busy, a.frame_done, a.core_x, a.core_y, a.fb_addr, a.fb_data, a.frame_count} !== '0) begin
            bad++;
            $display("FAIL reset_a: en/we/busy/done=%b%b%b%b x=%0d y=%0d addr=%0d data=%0d count=%0d need all 0",
                     a.core_enable, a.fb_we, a.busy, a.frame_done, a.core_x, a.core_y, a.fb_addr, a.fb_data, a.frame_count);
        end
        total++;
        if ({b.core_enable, b.fb_we, b.busy, b.frame_done, b.fb_addr, b.frame_count} !== '0) begin
            bad++;
            $display("FAIL reset_b: en/we/busy/done=%b%b%b%b addr=%0d count=%0d need all 0",
                     b.core_enable, b.fb_we, b.busy, b.frame_done, b.fb_addr, b.frame_count);
        end
        rst = 1'b0;
        a.core_ready = 1'b1; a.core_pixel = 4'h5; b.core_ready = 1'b1;
        cyc();
        total++;
        if ({a.busy, a.fb_we, a.fb_data, b.busy, b.fb_we} !== '0) begin
            bad++;
            $display("FAIL idle_ready_ignored: busy=%b we=%b data=%0d b_busy=%b b_we=%b need 0",
                     a.busy, a.fb_we, a.fb_data, b.busy, b.fb_we);
        end
    endtask

    task automatic test_single_frame();
        int n = 0;
        int g = 0;
        int dones = 0;
        logic [3:0] ed;
        core_lat = 2; a.continuous = 1'b0; a.fb_ready = 1'b1; pix_q.delete();
        a.start = 1'b1; cyc(); a.start = 1'b0;
        total++;
        if ({saw_en, a.busy, a.core_x, a.core_y} !== {1'b1, 1'b1, 10'd0, 9'd0}) begin
            bad++;
            $display("FAIL first_issue: en=%b busy=%b x=%0d y=%0d need 1 1 0 0", saw_en, a.busy, a.core_x, a.core_y);
        end
        while (n < NPIX && g < 400) begin
            cyc(); g++;
            dones += int'(saw_done);
            if (xfer) begin
                ed = (pix_q.size() > 0) ? pix_q.pop_front() : 4'bx;
                total++;
                if ({xa, xx, xy, xd} !== {19'(n), 10'(n % H), 9'(n / H), ed}) begin
                    bad++;
                    $display("FAIL frame_write: addr=%0d x=%0d y=%0d data=%0d need %0d %0d %0d %0d",
                             xa, xx, xy, xd, n, n % H, n / H, ed);
                end
                n++;
                total++;
                if (n < NPIX) begin
                    if ({saw_en, saw_done, a.core_x, a.core_y} !== {1'b1, 1'b0, 10'(n % H), 9'(n / H)}) begin
                        bad++;
                        $display("FAIL frame_next: en=%b done=%b x=%0d y=%0d need 1 0 %0d %0d",
                                 saw_en, saw_done, a.core_x, a.core_y, n % H, n / H);
                    end
                end else if ({saw_en, saw_done, a.busy} !== 3'b010) begin
                    bad++;
                    $display("FAIL frame_end: en=%b done=%b busy=%b need 0 1 0", saw_en, saw_done, a.busy);
                end
            end else begin
                total++;
                if ({saw_en, saw_done} !== 2'b00) begin
                    bad++;
                    $display("FAIL frame_stray: en=%b done=%b need 0 0", saw_en, saw_done);
                end
            end
        end
        exp_count++;
        total++;
        if (n != NPIX || dones != 1 || a.frame_count !== exp_count) begin
            bad++;
            $display("FAIL frame_summary: writes=%0d dones=%0d count=%0d need %0d 1 %0d", n, dones, a.frame_count, NPIX, exp_count);
        end
    endtask

    task automatic test_backpressure();
        int g = 0;
        logic [3:0] d0;
        core_lat = 2; a.continuous = 1'b0; a.fb_ready = 1'b1; pix_q.delete();
        a.start = 1'b1; cyc(); a.start = 1'b0;
        while (!(a.fb_we && a.fb_addr == 19'd1) && g < 100) begin cyc(); g++; end
        a.fb_ready = 1'b0;
        d0 = a.fb_data;
        total++;
        if (g >= 100 || pix_q.size() < 2 || d0 !== pix_q[1]) begin
            bad++;
            $display("FAIL bp_reach: cycles=%0d data=%0d queued=%0d", g, d0, pix_q.size());
        end
        repeat (5) begin
            cyc();
            total++;
            if ({a.fb_we, a.fb_addr, a.fb_data, a.core_x, a.core_y, saw_en} !== {1'b1, 19'd1, d0, 10'd1, 9'd0, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold: we=%b addr=%0d data=%0d x=%0d y=%0d en=%b need 1 1 %0d 1 0 0",
                         a.fb_we, a.fb_addr, a.fb_data, a.core_x, a.core_y, saw_en, d0);
            end
        end
        a.fb_ready = 1'b1; cyc();
        total++;
        if ({xfer, saw_en, a.fb_we, a.core_x, a.core_y} !== {1'b1, 1'b1, 1'b0, 10'd2, 9'd0}) begin
            bad++;
            $display("FAIL bp_release: xfer=%b en=%b we=%b x=%0d y=%0d need 1 1 0 2 0", xfer, saw_en, a.fb_we, a.core_x, a.core_y);
        end
        a.abort = 1'b1; cyc(); a.abort = 1'b0;
        total++;
        if ({a.busy, a.core_enable, a.fb_we, a.frame_done, a.frame_count} !== {4'b0, exp_count}) begin
            bad++;
            $display("FAIL abort_issue: busy=%b en=%b we=%b done=%b count=%0d need 0 0 0 0 %0d",
                     a.busy, a.core_enable, a.fb_we, a.frame_done, a.frame_count, exp_count);
        end
        lat_cnt = 0; pix_q.delete();
        cyc();
    endtask

    task automatic test_continuous();
        int n = 0;
        int g = 0;
        int k;
        logic [3:0] ed;
        core_lat = 0; a.continuous = 1'b1; pix_q.delete();
        a.start = 1'b1; cyc(); a.start = 1'b0;
        while (n < 2 * NPIX && g < 2000) begin
            a.fb_ready = ($urandom_range(3, 0) != 0);
            if (n == 2 * NPIX - 1) a.continuous = 1'b0;
            cyc(); g++;
            if (xfer) begin
                k = n % NPIX;
                ed = (pix_q.size() > 0) ? pix_q.pop_front() : 4'bx;
                total++;
                if ({xa, xx, xy, xd} !== {19'(k), 10'(k % H), 9'(k / H), ed}) begin
                    bad++;
                    $display("FAIL cont_write: addr=%0d x=%0d y=%0d data=%0d need %0d %0d %0d %0d",
                             xa, xx, xy, xd, k, k % H, k / H, ed);
                end
                n++;
                if (n % NPIX == 0) exp_count++;
                total++;
                if ({saw_en, saw_done, a.busy, a.frame_count} !== {n < 2 * NPIX, n % NPIX == 0, n < 2 * NPIX, exp_count}) begin
                    bad++;
                    $display("FAIL cont_after_write: n=%0d en=%b done=%b busy=%b count=%0d need %b %b %b %0d",
                             n, saw_en, saw_done, a.busy, a.frame_count, n < 2 * NPIX, n % NPIX == 0, n < 2 * NPIX, exp_count);
                end
            end else begin
                total++;
                if ({saw_en, saw_done, a.busy} !== 3'b001) begin
                    bad++;
                    $display("FAIL cont_idle_cycle: en=%b done=%b busy=%b need 0 0 1", saw_en, saw_done, a.busy);
                end
            end
        end
        total++;
        if (n != 2 * NPIX) begin
            bad++;
            $display("FAIL cont_timeout: writes=%0d need %0d", n, 2 * NPIX);
        end
        a.fb_ready = 1'b1;
    endtask

    task automatic test_abort();
        int n = 0;
        int g = 0;
        logic [15:0] c0;
        c0 = exp_count;
        core_lat = 2; a.continuous = 1'b0; a.fb_ready = 1'b1; pix_q.delete(); core_on = 1'b1;
        a.start = 1'b1; cyc(); a.start = 1'b0;
        while (!(saw_en && n == 5) && g < 200) begin cyc(); g++; if (xfer) n++; end
        core_on = 1'b0;
        cyc();
        a.abort = 1'b1; cyc(); a.abort = 1'b0;
        total++;
        if (g >= 200 || {a.busy, a.core_enable, a.fb_we} !== 3'b000) begin
            bad++;
            $display("FAIL abort_wait: cycles=%0d busy=%b en=%b we=%b need busy/en/we 0", g, a.busy, a.core_enable, a.fb_we);
        end
        cyc(); cyc();
        a.core_ready = 1'b1; a.core_pixel = 4'ha;
        repeat (4) begin
            cyc();
            total++;
            if ({a.busy, a.fb_we, a.core_enable, a.frame_done, a.frame_count} !== {4'b0, c0}) begin
                bad++;
                $display("FAIL abort_late_ready: busy=%b we=%b en=%b done=%b count=%0d need 0 0 0 0 %0d",
                         a.busy, a.fb_we, a.core_enable, a.frame_done, a.frame_count, c0);
            end
        end
        core_on = 1'b1; lat_cnt = 0; pix_q.delete();
        a.start = 1'b1; cyc(); a.start = 1'b0;
        total++;
        if ({saw_en, a.core_x, a.core_y} !== {1'b1, 10'd0, 9'd0}) begin
            bad++;
            $display("FAIL abort_restart: en=%b x=%0d y=%0d need 1 0 0", saw_en, a.core_x, a.core_y);
        end
        g = 0;
        do begin cyc(); g++; end while (!xfer && g < 50);
        total++;
        if (pix_q.size() == 0 || {xfer, xa, xd} !== {1'b1, 19'd0, pix_q[0]}) begin
            bad++;
            $display("FAIL abort_restart_write: xfer=%b addr=%0d data=%0d need 1 0 first pixel", xfer, xa, xd);
        end
        a.abort = 1'b1; cyc(); a.abort = 1'b0;
        pix_q.delete(); lat_cnt = 0;
    endtask

    task automatic test_start_ignored();
        int n = 0;
        int g = 0;
        a.start = 1'b1; a.abort = 1'b1; cyc(); a.start = 1'b0; a.abort = 1'b0;
        total++;
        if ({a.busy, saw_en} !== 2'b00) begin
            bad++;
            $display("FAIL start_abort_idle: busy=%b en=%b need 0 0", a.busy, saw_en);
        end
        cyc();
        total++;
        if ({a.busy, saw_en} !== 2'b00) begin
            bad++;
            $display("FAIL start_abort_idle_late: busy=%b en=%b need 0 0", a.busy, saw_en);
        end
        core_lat = 0; a.continuous = 1'b0; pix_q.delete();
        a.start = 1'b1; cyc(); a.start = 1'b0;
        while (n < NPIX && g < 1000) begin
            a.start = 1'($urandom_range(1, 0));
            a.fb_ready = ($urandom_range(2, 0) != 0);
            cyc(); g++;
            if (xfer) begin
                total++;
                if ({xa, xx, xy, xd} !== {19'(n), 10'(n % H), 9'(n / H), pix_q[0]}) begin
                    bad++;
                    $display("FAIL busy_start_write: addr=%0d x=%0d y=%0d data=%0d need %0d %0d %0d %0d",
                             xa, xx, xy, xd, n, n % H, n / H, pix_q[0]);
                end
                void'(pix_q.pop_front());
                n++;
            end else begin
                total++;
                if (saw_en !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_start_enable: en=%b need 0 at write count %0d", saw_en, n);
                end
            end
        end
        a.start = 1'b0; a.fb_ready = 1'b1;
        exp_count++;
        total++;
        if (n != NPIX || {a.busy, a.frame_count} !== {1'b0, exp_count}) begin
            bad++;
            $display("FAIL busy_start_end: writes=%0d busy=%b count=%0d need %0d 0 %0d", n, a.busy, a.frame_count, NPIX, exp_count);
        end
    endtask

    task automatic test_reset_mid_write();
        int g = 0;
        core_lat = 2; a.fb_ready = 1'b0; pix_q.delete();
        a.start = 1'b1; cyc(); a.start = 1'b0;
        while (!a.fb_we && g < 50) begin cyc(); g++; end
        #2 rst = 1'b1;
        #1;
        total++;
        if (g >= 50 || {a.core_enable, a.fb_we, a.busy, a.frame_done, a.core_x, a.core_y, a.fb_addr, a.fb_data, a.frame_count} !== '0) begin
            bad++;
            $display("FAIL reset_mid_write: cycles=%0d we=%b busy=%b addr=%0d data=%0d count=%0d need all 0",
                     g, a.fb_we, a.busy, a.fb_addr, a.fb_data, a.frame_count);
        end
        #2 rst = 1'b0;
        a.fb_ready = 1'b1; lat_cnt = 0; b_lat_cnt = 0; pix_q.delete(); b_pix_q.delete();
        exp_count = 16'd0; b_exp_count = 16'd0;
        cyc();
        total++;
        if ({a.busy, a.fb_we, a.frame_count} !== {2'b00, exp_count}) begin
            bad++;
            $display("FAIL reset_release: busy=%b we=%b count=%0d need 0 0 0", a.busy, a.fb_we, a.frame_count);
        end
    endtask

    task automatic test_one_pixel();
        int n = 0;
        int g = 0;
        logic [3:0] ed;
        b.continuous = 1'b0; b.fb_ready = 1'b0;
        b.start = 1'b1; cyc(); b.start = 1'b0;
        while (!b.fb_we && g < 50) begin cyc(); g++; end
        b.fb_ready = 1'b1; b.abort = 1'b1; cyc(); b.abort = 1'b0;
        total++;
        if (g >= 50 || {b.busy, b.fb_we, b_done, b.frame_count} !== {3'b000, b_exp_count}) begin
            bad++;
            $display("FAIL abort_drops_write: busy=%b we=%b done=%b count=%0d need 0 0 0 %0d",
                     b.busy, b.fb_we, b_done, b.frame_count, b_exp_count);
        end
        b_lat_cnt = 0; b_pix_q.delete();
        force b_dut.count_q = 16'hfffe;
        cyc();
        release b_dut.count_q;
        b_exp_count = 16'hfffe;
        b.continuous = 1'b1;
        b.start = 1'b1; cyc(); b.start = 1'b0;
        g = 0;
        while (n < 4 && g < 200) begin
            cyc(); g++;
            if (b_xfer) begin
                ed = (b_pix_q.size() > 0) ? b_pix_q.pop_front() : 4'bx;
                b_exp_count++;
                total++;
                if ({b_xa, b_xd, b_done, b_en, b.frame_count, b.core_x, b.core_y} !== {19'd0, ed, 1'b1, 1'b1, b_exp_count, 10'd0, 9'd0}) begin
                    bad++;
                    $display("FAIL one_pixel_frame: addr=%0d data=%0d done=%b en=%b count=%0d x=%0d y=%0d need 0 %0d 1 1 %0d 0 0",
                             b_xa, b_xd, b_done, b_en, b.frame_count, b.core_x, b.core_y, ed, b_exp_count);
                end
                n++;
            end else begin
                total++;
                if ({b_done, b_en, b.busy} !== 3'b001) begin
                    bad++;
                    $display("FAIL one_pixel_gap: done=%b en=%b busy=%b need 0 0 1", b_done, b_en, b.busy);
                end
            end
        end
        total++;
        if (n != 4 || b.frame_count !== 16'd2) begin
            bad++;
            $display("FAIL one_pixel_wrap: frames=%0d count=%0d need 4 2", n, b.frame_count);
        end
        b.continuous = 1'b0; b.abort = 1'b1; cyc(); b.abort = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_continuous();
        test_abort();
        test_start_ignored();
        test_reset_mid_write();
        test_one_pixel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rt_pixel_scheduler.md
Name: rt_pixel_scheduler

Overview:
- Parametrised frame scan sequencer for the ray-tracing core: walks (X,Y) over an H_RES x V_RES frame in raster order.
- Per pixel: pulses the core enable, waits for the core result, then writes the pixel to the framebuffer with a valid/ready handshake.
- Sits between the frame controller and RTcore / framebuffer write port.
- Supports single-frame and continuous modes, abort, and frame counting.

Parameters:
- H_RES, 640, pixels per row (>=1)
- V_RES, 480, rows per frame (>=1)
- PIX_W, 4, core pixel width
- XW, 10, X coordinate width (2^XW >= H_RES)
- YW, 9, Y coordinate width (2^YW >= V_RES)
- AW, 19, framebuffer address width (2^AW >= H_RES*V_RES)

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  begin a frame (sampled only in IDLE)
- CONTINUOUS  in  1  1 = restart automatically at end of frame
- ABORT  in  1  synchronous abort to IDLE
- CORE_ENABLE  out  1  single-cycle start pulse to core
- CORE_X  out  XW  pixel X to core
- CORE_Y  out  YW  pixel Y to core
- CORE_READY  in  1  core result valid
- CORE_PIXEL  in  PIX_W  core result
- FB_WE  out  1  framebuffer write valid
- FB_ADDR  out  AW  write address, equals Y*H_RES+X
- FB_DATA  out  PIX_W  write data
- FB_READY  in  1  framebuffer accepts write
- BUSY  out  1  high when not IDLE
- FRAME_DONE  out  1  one-cycle pulse at frame end
- FRAME_COUNT  out  16  completed frames, wraps 65535->0

Behaviour:
- Reset: state IDLE; all outputs 0, including X, Y, address and FRAME_COUNT. Reset applies immediately and asynchronously in any state.
- All outputs are registered.
- FB_ADDR is kept as an incrementing counter; no multiplier.
- IDLE:
  - START=1 at edge k: X=Y=addr=0, go to ISSUE.
  - CORE_ENABLE is high during cycle k+1.
  - CORE_READY is ignored in IDLE.
- ISSUE:
  - CORE_ENABLE=1 for exactly one cycle, then go to WAIT.
  - CORE_X/CORE_Y remain stable from ISSUE until the pixel's FB transfer completes.
- WAIT:
  - CORE_READY is sampled only here.
  - On CORE_READY: FB_DATA<=CORE_PIXEL, FB_WE<=1, go to WRITE.
  - The wait is unbounded; there is no timeout.
- WRITE:
  - FB_WE, FB_ADDR and FB_DATA hold until FB_WE&&FB_READY at an edge (transfer). On transfer, FB_WE<=0.
  - If X<H_RES-1: X++, addr++, go to ISSUE.
  - Else if Y<V_RES-1: X=0, Y++, addr++, go to ISSUE.
  - Else (last pixel): FRAME_DONE=1 for the next cycle and FRAME_COUNT++.
    - If CONTINUOUS=1 at that edge: X=Y=addr=0, go to ISSUE. There is no idle gap between frames.
    - Otherwise go to IDLE.
- Throughput: at most 3 cycles per pixel plus core latency. The next CORE_ENABLE is high in the cycle after the transfer edge.
- ABORT (highest priority after RESET):
  - At the next edge: go to IDLE; CORE_ENABLE=0, FB_WE=0.
  - No FRAME_DONE is generated and FRAME_COUNT is unchanged.
  - A late CORE_READY from an aborted pixel is discarded.
  - A pending write is dropped even if FB_READY is high in the same cycle.
- Simultaneous events:
  - START and ABORT together in IDLE: ABORT wins; stay in IDLE.
  - START outside IDLE: ignored.
- H_RES=1 and/or V_RES=1 are legal:
  - X (resp. Y) stays 0.
  - H_RES=V_RES=1: each frame is one pixel; FRAME_DONE follows every write.
- BUSY=0 exactly in IDLE, including the cycle after abort or after a single-frame end.

Test Plan:
- H_RES=4, V_RES=3. Core answers 2 cycles after enable, FB_READY=1, START pulse -> 12 writes, FB_ADDR 0..11, (X,Y) raster from (0,0) to (3,2), one FRAME_DONE, FRAME_COUNT=1, BUSY low afterwards.
- Backpressure: hold FB_READY=0 for 5 cycles at pixel (1,0) -> FB_WE=1, FB_ADDR=1 and FB_DATA all stable; no CORE_ENABLE until the transfer; next enable is at (2,0).
- CONTINUOUS=1 for two frames -> FB_ADDR returns from 11 to 0 with ISSUE directly after the last transfer, FRAME_COUNT=2, two FRAME_DONE pulses, BUSY never drops.
- ABORT in WAIT at pixel 5, then CORE_READY 3 cycles later -> IDLE, no FB_WE, FRAME_COUNT unchanged. A new START begins at (0,0), addr 0.
- START during a frame is ignored. START and ABORT together in IDLE -> remains IDLE. RESET asserted mid-WRITE -> all outputs 0 immediately.
- H_RES=V_RES=1, CONTINUOUS=1 -> repeating enable/ready/write at (0,0), addr 0; FRAME_DONE after every write; FRAME_COUNT increments and wraps 65535->0 (preload via long run or force).
